gpu_mem_arbiter: RTL and testbench

//  Shares the single GPU VRAM command port (32-byte line, 15-bit address) between NUM_REQ requesters.

---
 rtl/gpu_mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_gpu_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing one VRAM command port; registered output stage, in-order read return via owner tags.
// Optional: define GPU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module gpu_mem_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int RD_DEPTH = 4,
    parameter int ID_W     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NUM_REQ-1:0]      req_command_i,
    input  logic [2*NUM_REQ-1:0]    req_size_i,
    input  logic [NUM_REQ-1:0]      req_write_i,
    input  logic [15*NUM_REQ-1:0]   req_addr_i,
    input  logic [3*NUM_REQ-1:0]    req_sub_addr_i,
    input  logic [16*NUM_REQ-1:0]   req_write_mask_i,
    input  logic [256*NUM_REQ-1:0]  req_data_out_i,
    output logic [NUM_REQ-1:0]      req_busy_o,
    output logic [NUM_REQ-1:0]      req_data_in_valid_o,
    output logic [255:0]            req_data_in_o,
    output logic                    gpu_command_o,
    output logic [1:0]              gpu_size_o,
    output logic                    gpu_write_o,
    output logic [14:0]             gpu_addr_o,
    output logic [2:0]              gpu_sub_addr_o,
    output logic [15:0]             gpu_write_mask_o,
    output logic [255:0]            gpu_data_out_o,
    input  logic                    gpu_busy_i,
    input  logic                    gpu_data_in_valid_i,
    input  logic [255:0]            gpu_data_in_i,
    output logic [ID_W:0]           rd_pending_o,
    output logic                    err_o
);

    localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

    logic            cmd_q, cmd_d;
    logic [1:0]      size_q, size_d;
    logic            write_q, write_d;
    logic [14:0]     addr_q, addr_d;
    logic [2:0]      sub_q, sub_d;
    logic [15:0]     mask_q, mask_d;
    logic [255:0]    data_q, data_d;

    logic [ID_W-1:0] tag_mem_q [RD_DEPTH];
    logic [ID_W-1:0] tag_mem_d [RD_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ID_W:0]   count_q, count_d;
    logic            err_q, err_d;
`ifndef GPU_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]    win;
    logic               found;
    logic               can_load;
    logic               grant_vld;
    logic               rd_full;
    logic               push;
    logic               pop;
    logic [ID_W-1:0]    head;

    assign rd_full  = (count_q == (ID_W+1)'(RD_DEPTH));
    assign can_load = ~cmd_q | ~gpu_busy_i;
    assign elig     = req_command_i & (req_write_i | {NUM_REQ{~rd_full}});

    always_comb begin
        found = 1'b0;
        win   = '0;
`ifdef GPU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[i]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
`else
        // Circular search starting just after the last winner.
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
`endif
    end

    assign grant_vld = rst_n_i & can_load & found;

    always_comb begin
        gnt_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_oh[k] = grant_vld && (win == ID_W'(k));
        end
    end

    assign req_busy_o = ~gnt_oh;

    // Output stage: a drain with no new grant empties it, a stall holds it.
    always_comb begin
        int wi;
        wi      = int'(win);
        cmd_d   = cmd_q;
        size_d  = size_q;
        write_d = write_q;
        addr_d  = addr_q;
        sub_d   = sub_q;
        mask_d  = mask_q;
        data_d  = data_q;
        if (can_load) begin
            cmd_d = grant_vld;
        end
        if (grant_vld) begin
            size_d  = req_size_i[wi*2 +: 2];
            write_d = req_write_i[wi];
            addr_d  = req_addr_i[wi*15 +: 15];
            sub_d   = req_sub_addr_i[wi*3 +: 3];
            mask_d  = req_write_mask_i[wi*16 +: 16];
            data_d  = req_data_out_i[wi*256 +: 256];
        end
    end

`ifndef GPU_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = win;
        end
    end
`endif

    assign push = grant_vld & ~req_write_i[win];
    assign pop  = gpu_data_in_valid_i & (count_q != '0);
    assign head = tag_mem_q[rd_ptr_q];

    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q | (gpu_data_in_valid_i & (count_q == '0));
        if (push) begin
            tag_mem_d[wr_ptr_q] = win;
            wr_ptr_d = (wr_ptr_q == PW'(RD_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(RD_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        req_data_in_valid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_data_in_valid_o[k] = rst_n_i && pop && (head == ID_W'(k));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cmd_q    <= 1'b0;
            size_q   <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            sub_q    <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < RD_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
`ifndef GPU_ARB_FIXED_PRIO_EN
            rr_ptr_q <= ID_W'(NUM_REQ-1);
`endif
        end else begin
            cmd_q     <= cmd_d;
            size_q    <= size_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            sub_q     <= sub_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            tag_mem_q <= tag_mem_d;
`ifndef GPU_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    assign gpu_command_o    = cmd_q;
    assign gpu_size_o       = size_q;
    assign gpu_write_o      = write_q;
    assign gpu_addr_o       = addr_q;
    assign gpu_sub_addr_o   = sub_q;
    assign gpu_write_mask_o = mask_q;
    assign gpu_data_out_o   = data_q;
    assign req_data_in_o    = gpu_data_in_i;
    assign rd_pending_o     = count_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed vector table plus a short push/pop sequence for gpu_mem_arbiter (round-robin build).
module tb_gpu_mem_arbiter;

    logic           clk_i = 1'b0;
    logic           rst_n_i;
    logic [3:0]     req_command_i;
    logic [7:0]     req_size_i;
    logic [3:0]     req_write_i;
    logic [59:0]    req_addr_i;
    logic [11:0]    req_sub_addr_i;
    logic [63:0]    req_write_mask_i;
    logic [1023:0]  req_data_out_i;
    logic [3:0]     req_busy_o;
    logic [3:0]     req_data_in_valid_o;
    logic [255:0]   req_data_in_o;
    logic           gpu_command_o;
    logic [1:0]     gpu_size_o;
    logic           gpu_write_o;
    logic [14:0]    gpu_addr_o;
    logic [2:0]     gpu_sub_addr_o;
    logic [15:0]    gpu_write_mask_o;
    logic [255:0]   gpu_data_out_o;
    logic           gpu_busy_i;
    logic           gpu_data_in_valid_i;
    logic [255:0]   gpu_data_in_i;
    logic [2:0]     rd_pending_o;
    logic           err_o;

    gpu_mem_arbiter #(.NUM_REQ(4), .RD_DEPTH(4), .ID_W(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_command_i(req_command_i), .req_size_i(req_size_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_sub_addr_i(req_sub_addr_i),
        .req_write_mask_i(req_write_mask_i), .req_data_out_i(req_data_out_i),
        .req_busy_o(req_busy_o), .req_data_in_valid_o(req_data_in_valid_o),
        .req_data_in_o(req_data_in_o), .gpu_command_o(gpu_command_o), .gpu_size_o(gpu_size_o),
        .gpu_write_o(gpu_write_o), .gpu_addr_o(gpu_addr_o), .gpu_sub_addr_o(gpu_sub_addr_o),
        .gpu_write_mask_o(gpu_write_mask_o), .gpu_data_out_o(gpu_data_out_o),
        .gpu_busy_i(gpu_busy_i), .gpu_data_in_valid_i(gpu_data_in_valid_i),
        .gpu_data_in_i(gpu_data_in_i), .rd_pending_o(rd_pending_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst_n;
        logic [3:0]  cmd;
        logic [3:0]  wr;
        logic        busy;
        logic        dvld;
        logic [7:0]  dat;
        logic [3:0]  e_busy;
        logic        e_cmd;
        logic [14:0] e_addr;
        logic        e_wr;
        logic [3:0]  e_dv;
        logic [2:0]  e_pend;
        logic        e_err;
    } vec_t;

    vec_t tbl [43];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic [3:0] c, logic [3:0] w, logic b, logic dv, logic [7:0] d,
                                logic [3:0] eb, logic ec, logic [14:0] ea, logic ew, logic [3:0] edv,
                                logic [2:0] ep, logic ee);
        vec_t v;
        v.rst_n = r; v.cmd = c; v.wr = w; v.busy = b; v.dvld = dv; v.dat = d;
        v.e_busy = eb; v.e_cmd = ec; v.e_addr = ea; v.e_wr = ew; v.e_dv = edv; v.e_pend = ep; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] c, input logic [3:0] w, input logic b,
                         input logic dv, input logic [7:0] d);
        rst_n_i             = r;
        req_command_i       = c;
        req_write_i         = w;
        gpu_busy_i          = b;
        gpu_data_in_valid_i = dv;
        gpu_data_in_i       = {32{d}};
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            req_addr_i[k*15 +: 15]        = 15'h1234 + 15'(k);
            req_size_i[k*2 +: 2]          = 2'(k % 3);
            req_sub_addr_i[k*3 +: 3]      = 3'(k);
            req_write_mask_i[k*16 +: 16]  = 16'hF00F ^ 16'(k);
            req_data_out_i[k*256 +: 256]  = {32{8'(8'hA0 + k)}};
        end
        // single writer
        tbl[0]  = mk(0, 4'b0000, 4'b0000, 0, 0, 8'h00, 4'b1111, 0, 15'h0000, 0, 4'b0000, 0, 0);
        tbl[1]  = mk(1, 4'b0001, 4'b0001, 0, 0, 8'h00, 4'b1110, 0, 15'h0000, 0, 4'b0000, 0, 0);
        tbl[2]  = mk(1, 4'b0000, 4'b0000, 0, 0, 8'h00, 4'b1111, 1, 15'h1234, 1, 4'b0000, 0, 0);
        tbl[3]  = mk(1, 4'b0000, 4'b0000, 0, 0, 8'h00, 4'b1111, 0, 15'h1234, 1, 4'b0000, 0, 0);
        // four continuous writers, rotation resumes after last winner 0
        tbl[4]  = mk(1, 4'b1111, 4'b1111, 0, 0, 8'h00, 4'b1101, 0, 15'h1234, 1, 4'b0000, 0, 0);
        tbl[5]  = mk(1, 4'b1111, 4'b1111, 0, 0, 8'h00, 4'b1011, 1, 15'h1235, 1, 4'b0000, 0, 0);
        tbl[6]  = mk(1, 4'b1111, 4'b1111, 0, 0, 8'h00, 4'b0111, 1, 15'h1236, 1, 4'b0000, 0, 0);
        tbl[7]  = mk(1, 4'b1111, 4'b1111, 0, 0, 8'h00, 4'b1110, 1, 15'h1237, 1, 4'b0000, 0, 0);
        tbl[8]  = mk(1, 4'b1111, 4'b1111, 0, 0, 8'h00, 4'b1101, 1, 15'h1234, 1, 4'b0000, 0, 0);
        // downstream stall for 5 cycles, then release
        for (int i = 9; i <= 13; i++)
            tbl[i] = mk(1, 4'b1111, 4'b1111, 1, 0, 8'h00, 4'b1111, 1, 15'h1235, 1, 4'b0000, 0, 0);
        tbl[14] = mk(1, 4'b1111, 4'b1111, 0, 0, 8'h00, 4'b1011, 1, 15'h1235, 1, 4'b0000, 0, 0);
        tbl[15] = mk(1, 4'b0000, 4'b0000, 0, 0, 8'h00, 4'b1111, 1, 15'h1236, 1, 4'b0000, 0, 0);
        tbl[16] = mk(1, 4'b0000, 4'b0000, 0, 0, 8'h00, 4'b1111, 0, 15'h1236, 1, 4'b0000, 0, 0);
        // reads from 2,0,3,1 then four beats
        tbl[17] = mk(1, 4'b0100, 4'b0000, 0, 0, 8'h00, 4'b1011, 0, 15'h1236, 1, 4'b0000, 0, 0);
        tbl[18] = mk(1, 4'b0001, 4'b0000, 0, 0, 8'h00, 4'b1110, 1, 15'h1236, 0, 4'b0000, 1, 0);
        tbl[19] = mk(1, 4'b1000, 4'b0000, 0, 0, 8'h00, 4'b0111, 1, 15'h1234, 0, 4'b0000, 2, 0);
        tbl[20] = mk(1, 4'b0010, 4'b0000, 0, 0, 8'h00, 4'b1101, 1, 15'h1237, 0, 4'b0000, 3, 0);
        tbl[21] = mk(1, 4'b0000, 4'b0000, 0, 1, 8'hD0, 4'b1111, 1, 15'h1235, 0, 4'b0100, 4, 0);
        tbl[22] = mk(1, 4'b0000, 4'b0000, 0, 1, 8'hD1, 4'b1111, 0, 15'h1235, 0, 4'b0001, 3, 0);
        tbl[23] = mk(1, 4'b0000, 4'b0000, 0, 1, 8'hD2, 4'b1111, 0, 15'h1235, 0, 4'b1000, 2, 0);
        tbl[24] = mk(1, 4'b0000, 4'b0000, 0, 1, 8'hD3, 4'b1111, 0, 15'h1235, 0, 4'b0010, 1, 0);
        // fill the tag FIFO; fifth read blocked, write still passes, pop unblocks a cycle later
        tbl[25] = mk(1, 4'b1111, 4'b0000, 0, 0, 8'h00, 4'b1011, 0, 15'h1235, 0, 4'b0000, 0, 0);
        tbl[26] = mk(1, 4'b1111, 4'b0000, 0, 0, 8'h00, 4'b0111, 1, 15'h1236, 0, 4'b0000, 1, 0);
        tbl[27] = mk(1, 4'b1111, 4'b0000, 0, 0, 8'h00, 4'b1110, 1, 15'h1237, 0, 4'b0000, 2, 0);
        tbl[28] = mk(1, 4'b1111, 4'b0000, 0, 0, 8'h00, 4'b1101, 1, 15'h1234, 0, 4'b0000, 3, 0);
        tbl[29] = mk(1, 4'b1111, 4'b0000, 0, 0, 8'h00, 4'b1111, 1, 15'h1235, 0, 4'b0000, 4, 0);
        tbl[30] = mk(1, 4'b1111, 4'b0001, 0, 0, 8'h00, 4'b1110, 0, 15'h1235, 0, 4'b0000, 4, 0);
        tbl[31] = mk(1, 4'b1110, 4'b0000, 0, 1, 8'hB0, 4'b1111, 1, 15'h1234, 1, 4'b0100, 4, 0);
        tbl[32] = mk(1, 4'b1110, 4'b0000, 0, 0, 8'h00, 4'b1101, 0, 15'h1234, 1, 4'b0000, 3, 0);
        tbl[33] = mk(1, 4'b0000, 4'b0000, 0, 0, 8'h00, 4'b1111, 1, 15'h1235, 0, 4'b0000, 4, 0);
        tbl[34] = mk(1, 4'b0000, 4'b0000, 0, 1, 8'hC0, 4'b1111, 0, 15'h1235, 0, 4'b1000, 4, 0);
        tbl[35] = mk(1, 4'b0000, 4'b0000, 0, 1, 8'hC1, 4'b1111, 0, 15'h1235, 0, 4'b0001, 3, 0);
        tbl[36] = mk(1, 4'b0000, 4'b0000, 0, 1, 8'hC2, 4'b1111, 0, 15'h1235, 0, 4'b0010, 2, 0);
        tbl[37] = mk(1, 4'b0000, 4'b0000, 0, 1, 8'hC3, 4'b1111, 0, 15'h1235, 0, 4'b0010, 1, 0);
        // empty pop -> sticky error; reset mid-burst clears everything
        tbl[38] = mk(1, 4'b0000, 4'b0000, 0, 1, 8'hE0, 4'b1111, 0, 15'h1235, 0, 4'b0000, 0, 0);
        tbl[39] = mk(1, 4'b1111, 4'b1011, 0, 0, 8'h00, 4'b1011, 0, 15'h1235, 0, 4'b0000, 0, 1);
        tbl[40] = mk(1, 4'b1111, 4'b1011, 0, 0, 8'h00, 4'b0111, 1, 15'h1236, 0, 4'b0000, 1, 1);
        tbl[41] = mk(0, 4'b1111, 4'b1011, 0, 0, 8'h00, 4'b1111, 1, 15'h1237, 1, 4'b0000, 1, 1);
        tbl[42] = mk(1, 4'b0000, 4'b0000, 0, 0, 8'h00, 4'b1111, 0, 15'h0000, 0, 4'b0000, 0, 0);

        drive(0, 4'b0000, 4'b0000, 0, 0, 8'h00);
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < 43; i++) begin
            @(negedge clk_i);
            drive(tbl[i].rst_n, tbl[i].cmd, tbl[i].wr, tbl[i].busy, tbl[i].dvld, tbl[i].dat);
            #1;
            chk($sformatf("v%0d busy", i),  256'(req_busy_o),          256'(tbl[i].e_busy));
            chk($sformatf("v%0d cmd", i),   256'(gpu_command_o),       256'(tbl[i].e_cmd));
            chk($sformatf("v%0d addr", i),  256'(gpu_addr_o),          256'(tbl[i].e_addr));
            chk($sformatf("v%0d write", i), 256'(gpu_write_o),         256'(tbl[i].e_wr));
            chk($sformatf("v%0d dvalid", i), 256'(req_data_in_valid_o), 256'(tbl[i].e_dv));
            chk($sformatf("v%0d pend", i),  256'(rd_pending_o),        256'(tbl[i].e_pend));
            chk($sformatf("v%0d err", i),   256'(err_o),               256'(tbl[i].e_err));
            chk($sformatf("v%0d rdata", i), req_data_in_o,             {32{tbl[i].dat}});
        end

        // Simultaneous push and pop: occupancy holds, order preserved.
        @(negedge clk_i);
        drive(1, 4'b0001, 4'b0000, 0, 0, 8'h00);
        #1 chk("pp grant0", 256'(req_busy_o), 256'(4'b1110));
        @(negedge clk_i);
        drive(1, 4'b0010, 4'b0000, 0, 1, 8'h5A);
        #1 chk("pp grant1", 256'(req_busy_o), 256'(4'b1101));
        chk("pp strobe0", 256'(req_data_in_valid_o), 256'(4'b0001));
        chk("pp pend a", 256'(rd_pending_o), 256'(3'd1));
        @(negedge clk_i);
        drive(1, 4'b0000, 4'b0000, 0, 1, 8'h6B);
        #1 chk("pp pend b", 256'(rd_pending_o), 256'(3'd1));
        chk("pp strobe1", 256'(req_data_in_valid_o), 256'(4'b0010));
        @(negedge clk_i);
        drive(1, 4'b0000, 4'b0000, 0, 0, 8'h00);
        #1 chk("pp pend c", 256'(rd_pending_o), 256'(3'd0));
        chk("pp err", 256'(err_o), 256'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
